// File: rtl/nec_uart_packetizer_if.sv
// nec_uart_packetizer_if
//   Bundles the packetizer's frame-input, UART-handshake and status signals.
//   Signal names keep their i_/o_ prefixes as seen from the packetizer itself.
//   Signals:
//     i_frame_valid  1-cycle strobe, i_frame holds a decoded NEC frame
//     i_frame[31:0]  [7:0]=addr [15:8]=~addr [23:16]=cmd [31:24]=~cmd
//     i_repeat       1-cycle strobe, NEC repeat code received
//     o_tx_valid     1-cycle strobe to the UART transmitter
//     o_tx_data[7:0] byte to the UART transmitter, held until the next strobe
//     i_tx_done      1-cycle strobe from the UART transmitter, byte finished
//     o_busy         packetizer not idle or FIFO not empty
//     o_bad_frame    1-cycle pulse, frame failed the inversion check
//     o_drop         1-cycle pulse, packet lost because the FIFO was full
//     o_timeout      1-cycle pulse, UART never acknowledged, packet abandoned
//   Modports:
//     master  the surrounding system (decoder + UART side)
//     slave   the packetizer
interface nec_uart_packetizer_if;
  logic        i_frame_valid;
  logic [31:0] i_frame;
  logic        i_repeat;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_bad_frame;
  logic        o_drop;
  logic        o_timeout;

  modport master (
    output i_frame_valid, i_frame, i_repeat, i_tx_done,
    input  o_tx_valid, o_tx_data, o_busy, o_bad_frame, o_drop, o_timeout
  );

  modport slave (
    input  i_frame_valid, i_frame, i_repeat, i_tx_done,
    output o_tx_valid, o_tx_data, o_busy, o_bad_frame, o_drop, o_timeout
  );
endinterface

// File: rtl/nec_uart_packetizer.sv
// nec_uart_packetizer
//   Sits between the NEC frame decoder and the UART transmitter. Each decoded
//   frame is checked (addr/~addr, cmd/~cmd), repeat codes replay the last good
//   frame, packets are queued in a small FIFO and sent one byte per UART
//   handshake (o_tx_valid -> i_tx_done).
//   Packet: HDR_BYTE, TYPE (0x01 frame / 0x02 repeat), ADDR, CMD [, CHK].
//   Build option: define NEC_PKT_CHECKSUM_EN to append CHK = TYPE^ADDR^CMD
//   (5-byte packets); otherwise packets are 4 bytes.
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     bus  nec_uart_packetizer_if.slave (frame input, UART handshake, status)
//   Parameters:
//     FIFO_DEPTH   packet FIFO entries, power of 2, >= 2
//     HDR_BYTE     first byte of every packet
//     TIMEOUT_CYC  cycles waiting for i_tx_done before the packet is abandoned
module nec_uart_packetizer #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CYC = 200000
) (
  input logic                  clk,
  input logic                  rst,
  nec_uart_packetizer_if.slave bus
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

`ifdef NEC_PKT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef struct packed {
    logic       is_rep;
    logic [7:0] addr;
    logic [7:0] cmd;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  // Byte i of the packet described by e. Byte 0 is loaded straight from
  // HDR_BYTE when a packet is popped, the rest come from here.
  function automatic logic [7:0] pkt_byte(input entry_t e, input logic [2:0] i);
    logic [7:0] type_b;
    type_b = e.is_rep ? 8'h02 : 8'h01;
    case (i)
      3'd0:    pkt_byte = HDR_BYTE;
      3'd1:    pkt_byte = type_b;
      3'd2:    pkt_byte = e.addr;
      3'd3:    pkt_byte = e.cmd;
`ifdef NEC_PKT_CHECKSUM_EN
      3'd4:    pkt_byte = type_b ^ e.addr ^ e.cmd;
`endif
      default: pkt_byte = 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Frame check and push request
  // ---------------------------------------------------------------------------
  logic [7:0] f_addr, f_naddr, f_cmd, f_ncmd;
  logic       frame_good;
  logic       push_req;
  entry_t     push_entry;

  logic       last_valid;
  logic [7:0] last_addr, last_cmd;

  assign f_addr  = bus.i_frame[7:0];
  assign f_naddr = bus.i_frame[15:8];
  assign f_cmd   = bus.i_frame[23:16];
  assign f_ncmd  = bus.i_frame[31:24];

  assign frame_good = ((f_addr ^ f_naddr) == 8'hFF) && ((f_cmd ^ f_ncmd) == 8'hFF);

  // A frame strobe always wins over a coincident repeat strobe.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through it can leave a value held and infer a latch.
    push_req   = 1'b0;
    push_entry = '0;
    if (bus.i_frame_valid) begin
      push_req   = frame_good;
      push_entry = '{is_rep: 1'b0, addr: f_addr, cmd: f_cmd};
    end else if (bus.i_repeat && last_valid) begin
      push_req   = 1'b1;
      push_entry = '{is_rep: 1'b1, addr: last_addr, cmd: last_cmd};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      last_valid <= 1'b0;
      last_addr  <= 8'h00;
      last_cmd   <= 8'h00;
    end else if (bus.i_frame_valid && frame_good) begin
      last_valid <= 1'b1;
      last_addr  <= f_addr;
      last_cmd   <= f_cmd;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // Fullness is judged on the registered pointers, so a pop in the same cycle
  // never makes room for a push.
  // ---------------------------------------------------------------------------
  entry_t        mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          push_ok, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok    = push_req && !fifo_full;

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Status pulses, one cycle after the offending input
  // ---------------------------------------------------------------------------
  logic bad_frame_q, drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_frame_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      bad_frame_q <= bus.i_frame_valid && !frame_good;
      drop_q      <= push_req && fifo_full;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t         state, next_state;
  entry_t         cur;
  logic [2:0]     idx;
  logic [7:0]     tx_data_q;
  logic [WDW-1:0] wd;
  logic           wd_expired;

  assign wd_expired = (wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (!fifo_empty) next_state = S_SEND;
      S_SEND: next_state = S_WAIT;
      S_WAIT: begin
        if (bus.i_tx_done)   next_state = (idx == LAST_IDX) ? S_IDLE : S_SEND;
        else if (wd_expired) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  logic tx_valid, busy, timeout;

  always_comb begin
    tx_valid = (state == S_SEND);
    pop      = (state == S_IDLE) && !fifo_empty;
    busy     = (state != S_IDLE) || !fifo_empty;
    // i_tx_done in the expiry cycle still counts as an acknowledge.
    timeout  = (state == S_WAIT) && !bus.i_tx_done && wd_expired;
  end

  // Packet register, byte index, output byte and watchdog. o_tx_data is
  // loaded as the FSM enters SEND so it is valid together with the strobe
  // and holds until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= '0;
      idx       <= 3'd0;
      tx_data_q <= 8'h00;
      wd        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur       <= mem[rd_ptr[AW-1:0]];
            idx       <= 3'd0;
            tx_data_q <= HDR_BYTE;
          end
        end
        S_SEND: wd <= '0;
        S_WAIT: begin
          wd <= wd + 1'b1;
          if (bus.i_tx_done && idx != LAST_IDX) begin
            idx       <= idx + 3'd1;
            tx_data_q <= pkt_byte(cur, idx + 3'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_tx_valid  = tx_valid;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_busy      = busy;
  assign bus.o_bad_frame = bad_frame_q;
  assign bus.o_drop      = drop_q;
  assign bus.o_timeout   = timeout;

endmodule
